// File: rtl/fft8_input_loader.sv
// Serial-to-parallel input buffer for the 8-point FFT: collects eight complex
// samples, presents them as one parallel frame and holds it until accepted.
`timescale 1ns/1ps
module fft8_input_loader #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_real,
  input  logic [DATA_W-1:0]   in_imag,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*DATA_W-1:0] out_real,
  output logic [8*DATA_W-1:0] out_imag,
  output logic                err_frame,
  output logic [15:0]         frame_cnt
);

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               idx_q;
  logic signed [DATA_W-1:0] slot_re [8];
  logic signed [DATA_W-1:0] slot_im [8];
  logic                     err_q;
  logic [15:0]              cnt_q;
  logic                     beat, last_slot, frame_err, out_hs;

  assign beat      = in_valid & in_ready;
  assign last_slot = (idx_q == 3'd7);
  // A marker on the wrong slot, or a missing one on slot 7, is a framing error.
  assign frame_err = beat & (in_last ^ last_slot);
  assign out_hs    = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (beat && last_slot) state_d = FULL;
      FULL:    if (out_ready)         state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // in_ready depends on state only, so out_ready never reaches it combinationally.
  always_comb begin
    in_ready  = (state_q == FILL);
    out_valid = (state_q == FULL);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= 3'd0;
      err_q <= 1'b0;
      cnt_q <= 16'd0;
    end else begin
      if (beat) begin
        if (in_last || last_slot) idx_q <= 3'd0;
        else                      idx_q <= idx_q + 3'd1;
      end
      if (frame_err) err_q <= 1'b1;
      if (out_hs)    cnt_q <= cnt_q + 16'd1;
    end
  end

  // Sample store: written only in FILL, so the frame is frozen while FULL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        slot_re[k] <= '0;
        slot_im[k] <= '0;
      end
    end else if (beat) begin
      slot_re[idx_q] <= signed'(in_real);
      slot_im[idx_q] <= signed'(in_imag);
    end
  end

  always_comb begin
    out_real = '0;
    out_imag = '0;
    for (int k = 0; k < 8; k++) begin
      out_real[k*DATA_W +: DATA_W] = slot_re[k];
      out_imag[k*DATA_W +: DATA_W] = slot_im[k];
    end
  end

  assign err_frame = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fft8_input_loader.sv
// Self-checking bench for fft8_input_loader: directed scenarios plus a randomized
// back-to-back run scored against a frame-level reference queue.
`timescale 1ns/1ps
module tb_fft8_input_loader;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_real = '0;
  logic [W-1:0]   in_imag = '0;
  logic           in_last = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [8*W-1:0] out_real;
  logic [8*W-1:0] out_imag;
  logic           err_frame;
  logic [15:0]    frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_cnt = 16'd0;

  logic [W-1:0] fr_re [8];
  logic [W-1:0] fr_im [8];
  logic [8*W-1:0] exp_re_q [$];
  logic [8*W-1:0] exp_im_q [$];

  fft8_input_loader #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_real(in_real), .in_imag(in_imag), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_real(out_real), .out_imag(out_imag),
    .err_frame(err_frame), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [8*W-1:0] pack_re();
    logic [8*W-1:0] v;
    for (int k = 0; k < 8; k++) v[k*W +: W] = fr_re[k];
    return v;
  endfunction

  function automatic logic [8*W-1:0] pack_im();
    logic [8*W-1:0] v;
    for (int k = 0; k < 8; k++) v[k*W +: W] = fr_im[k];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one sample and returns just after the edge where it was accepted.
  task automatic send_sample(input logic [W-1:0] re, input logic [W-1:0] im,
                             input logic last);
    logic rdy;
    int   n;
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    in_last  = last;
    n = 0;
    do begin
      rdy = in_ready;
      tick();
      n++;
    end while (!rdy && n < 300);
    if (!rdy) begin
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
    end
    checks++;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic last_on_7);
    for (int k = 0; k < 8; k++)
      send_sample(fr_re[k], fr_im[k], (k == 7) ? last_on_7 : 1'b0);
  endtask

  task automatic fill_ramp(input int base);
    for (int k = 0; k < 8; k++) begin
      fr_re[k] = W'(base + k + 1);
      fr_im[k] = W'(-(base + k + 1));
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_frame !== 1'b0 || frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_ctrl: ov=%b ir=%b err=%b cnt=%0d, required 0 1 0 0",
               out_valid, in_ready, err_frame, frame_cnt);
    end
    checks++;
    if (out_real !== '0 || out_imag !== '0) begin
      errors++;
      $display("FAIL reset_slots: re=%h im=%h, required all zero", out_real, out_imag);
    end
    rst_n = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_basic();
    fill_ramp(0);
    out_ready = 1'b1;
    send_frame(1'b1);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: ov=%b ir=%b, required 1 0", out_valid, in_ready);
    end
    checks++;
    if (out_real[3*W +: W] !== 16'd4 || out_imag[3*W +: W] !== 16'hFFFC) begin
      errors++;
      $display("FAIL basic_slot3: (%h,%h), required (0004,fffc)",
               out_real[3*W +: W], out_imag[3*W +: W]);
    end
    checks++;
    if (out_real !== pack_re() || out_imag !== pack_im()) begin
      errors++;
      $display("FAIL basic_frame: re=%h im=%h, required re=%h im=%h",
               out_real, out_imag, pack_re(), pack_im());
    end
    tick();
    exp_cnt++;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL basic_handshake: ov=%b ir=%b cnt=%0d, required 0 1 %0d",
               out_valid, in_ready, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    fill_ramp(20);
    out_ready = 1'b0;
    send_frame(1'b1);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_real  = W'($urandom);
      in_imag  = W'($urandom);
      in_last  = 1'($urandom);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_real !== pack_re() || out_imag !== pack_im() || frame_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL hold_cycle%0d: ov=%b ir=%b cnt=%0d re=%h, required 1 0 %0d re=%h",
                 c, out_valid, in_ready, frame_cnt, out_real, exp_cnt, pack_re());
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_cnt++;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL hold_release: ov=%b ir=%b cnt=%0d, required 0 1 %0d",
               out_valid, in_ready, frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_runt();
    out_ready = 1'b1;
    send_sample(16'h0101, 16'h0202, 1'b0);
    send_sample(16'h0303, 16'h0404, 1'b0);
    send_sample(16'h0505, 16'h0606, 1'b1);
    checks++;
    if (err_frame !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL runt_flag: err=%b ov=%b ir=%b, required 1 0 1", err_frame, out_valid, in_ready);
    end
    fill_ramp(40);
    send_frame(1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_real[0 +: W] !== 16'd41 ||
        out_real !== pack_re() || out_imag !== pack_im()) begin
      errors++;
      $display("FAIL runt_next_frame: ov=%b re=%h, required 1 re=%h", out_valid, out_real, pack_re());
    end
    tick();
    exp_cnt++;
    checks++;
    if (frame_cnt !== exp_cnt || err_frame !== 1'b1) begin
      errors++;
      $display("FAIL runt_sticky: cnt=%0d err=%b, required %0d 1", frame_cnt, err_frame, exp_cnt);
    end
  endtask

  task automatic test_no_last();
    apply_reset();
    out_ready = 1'b0;
    fill_ramp(60);
    send_frame(1'b0);
    checks++;
    if (out_valid !== 1'b1 || err_frame !== 1'b1 || out_real !== pack_re() || out_imag !== pack_im()) begin
      errors++;
      $display("FAIL nolast: ov=%b err=%b re=%h, required 1 1 re=%h",
               out_valid, err_frame, out_real, pack_re());
    end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    checks++;
    if (frame_cnt !== exp_cnt || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL nolast_cnt: cnt=%0d ir=%b, required %0d 1", frame_cnt, in_ready, exp_cnt);
    end
  endtask

  task automatic test_mid_reset();
    fill_ramp(80);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_sample(fr_re[k], fr_im[k], 1'b0);
    rst_n = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_frame !== 1'b0 ||
        frame_cnt !== 16'd0 || out_real !== '0 || out_imag !== '0) begin
      errors++;
      $display("FAIL midreset: ov=%b ir=%b err=%b cnt=%0d re=%h, required 0 1 0 0 zero",
               out_valid, in_ready, err_frame, frame_cnt, out_real);
    end
    rst_n = 1'b1;
    exp_cnt = 16'd0;
    fill_ramp(100);
    send_frame(1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_real !== pack_re() || out_imag !== pack_im()) begin
      errors++;
      $display("FAIL midreset_frame: ov=%b re=%h, required 1 re=%h", out_valid, out_real, pack_re());
    end
    tick();
    exp_cnt++;
    checks++;
    if (frame_cnt !== 16'd1 || err_frame !== 1'b0) begin
      errors++;
      $display("FAIL midreset_cnt: cnt=%0d err=%b, required 1 0", frame_cnt, err_frame);
    end
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 3))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_back_to_back();
    localparam int NF = 24;
    int got = 0;
    exp_re_q.delete();
    exp_im_q.delete();
    fork
      begin
        for (int f = 0; f < NF; f++) begin
          for (int k = 0; k < 8; k++) begin
            fr_re[k] = rand_val();
            fr_im[k] = rand_val();
          end
          exp_re_q.push_back(pack_re());
          exp_im_q.push_back(pack_im());
          for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_sample(fr_re[k], fr_im[k], k == 7);
          end
        end
      end
      begin
        int cyc = 0;
        logic ov, rdy;
        logic [8*W-1:0] cr, ci;
        while (got < NF && cyc < 4000) begin
          rdy = ($urandom_range(0, 2) != 0);
          out_ready = rdy;
          ov = out_valid;
          cr = out_real;
          ci = out_imag;
          tick();
          cyc++;
          if (ov && rdy) begin
            checks++;
            if (exp_re_q.size() == 0) begin
              errors++;
              $display("FAIL b2b_extra: frame %0d delivered with nothing expected", got);
            end else begin
              if (cr !== exp_re_q[0] || ci !== exp_im_q[0]) begin
                errors++;
                $display("FAIL b2b_frame%0d: re=%h im=%h, required re=%h im=%h",
                         got, cr, ci, exp_re_q[0], exp_im_q[0]);
              end
              void'(exp_re_q.pop_front());
              void'(exp_im_q.pop_front());
            end
            got++;
            exp_cnt++;
          end
        end
        checks++;
        if (got != NF) begin
          errors++;
          $display("FAIL b2b_timeout: got %0d frames, required %0d", got, NF);
        end
      end
    join
    out_ready = 1'b0;
    checks++;
    if (frame_cnt !== exp_cnt || err_frame !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_final: cnt=%0d err=%b ov=%b, required %0d 0 0",
               frame_cnt, err_frame, out_valid, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_runt();
    test_no_last();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
